// File: rtl/jtag_seq_pkg.sv
// Purpose : shared TAP state encodings, command op codes, sequencer FSM states
//           and the IEEE 1149.1 TAP next-state function.
// Latency : n/a (types and a pure function only).
// Backpr. : n/a.
package jtag_seq_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR        = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR        = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_state_t;

  typedef enum logic [1:0] {
    OP_RESET   = 2'b00,
    OP_IR_SCAN = 2'b01,
    OP_DR_SCAN = 2'b10,
    OP_IDLE    = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    SEQ_INIT,
    SEQ_READY,
    SEQ_PRE,
    SEQ_SHIFT,
    SEQ_POST,
    SEQ_IDLE_RUN,
    SEQ_RESP
  } seq_state_t;

  // Number of TMS values emitted before the first shift bit (or, for RESET,
  // the run of ones that forces Test-Logic-Reset from any state).
  localparam int RESET_PRE_LEN = 5;
  localparam int IR_PRE_LEN    = 4;  // 1,1,0,0 : RTI->SelDR->SelIR->CapIR->ShiftIR
  localparam int DR_PRE_LEN    = 3;  // 1,0,0   : RTI->SelDR->CapDR->ShiftDR

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TEST_LOGIC_RESET: return tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    return tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        return tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       return tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         return tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         return tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         return tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         return tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        return tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        return tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       return tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         return tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         return tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         return tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         return tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        return tms ? SELECT_DR        : RUN_TEST_IDLE;
      default:          return TEST_LOGIC_RESET;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_mirror.sv
// Purpose : registered copy of the 16-state TAP controller, advanced by the TMS
//           value currently presented to the real TAP.
// Latency : state updates on the same tck edge as the real TAP.
// Backpr. : none; follows tms every cycle.
// Ports   : i_tck clock, i_trst_n async active-low reset, i_tms TMS seen by
//           the TAP, o_state mirrored TAP state.
module jtag_tap_mirror
  import jtag_seq_pkg::*;
(
  input  logic       i_tck,
  input  logic       i_trst_n,
  input  logic       i_tms,
  output tap_state_t o_state
);

  tap_state_t r_state;

  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) r_state <= TEST_LOGIC_RESET;
    else           r_state <= tap_next(r_state, i_tms);
  end

  assign o_state = r_state;

endmodule

// File: rtl/jtag_tap_sequencer.sv
// Purpose : command-driven JTAG master; turns RESET/IR/DR/IDLE commands into
//           registered TMS/TDI and returns captured TDO bits.
// Latency : IR k+N+6, DR k+N+5, RESET k+6, IDLE k+max(len,1), zero-length scan k+1.
// Backpr. : one command outstanding; response held (TAP idles in RTI) until rsp_ready.
// Ports   : tck/trst_n clock and async reset; cmd_* command channel; rsp_*
//           response channel; tms/tdi/tdo TAP pins; busy; tap_state mirror.
// Option  : JTAG_SEQ_TDO_PARITY_EN adds rsp_parity = XOR of the captured bits.
module jtag_tap_sequencer
  import jtag_seq_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               tck,
  input  logic               trst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
`ifdef JTAG_SEQ_TDO_PARITY_EN
  output logic               rsp_parity,
`endif
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               busy,
  output logic [3:0]         tap_state
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  seq_state_t         r_state;
  cmd_op_t            r_op;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_cap;
  logic [MAX_LEN-1:0] r_sr;
  logic [MAX_LEN-1:0] r_rsp;
  logic               r_tms;
  logic               r_tdi;
  logic               r_cmd_ready;
  logic               r_rsp_valid;
  logic               r_busy;

  tap_state_t         w_tap_state;
  logic [LEN_W-1:0]   w_n;
  logic               w_pre_last;
  logic               w_pre_tms;
  logic               w_capture;
  logic               w_rsp_set;

  jtag_tap_mirror u_mirror (
    .i_tck    (tck),
    .i_trst_n (trst_n),
    .i_tms    (r_tms),
    .o_state  (w_tap_state)
  );

  assign w_n = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;

  always_comb begin
    w_pre_last = 1'b0;
    case (r_op)
      OP_RESET:   w_pre_last = (r_cnt == LEN_W'(RESET_PRE_LEN - 1));
      OP_IR_SCAN: w_pre_last = (r_cnt == LEN_W'(IR_PRE_LEN - 1));
      default:    w_pre_last = (r_cnt == LEN_W'(DR_PRE_LEN - 1));
    endcase
  end

  // Prefix element 0 (always 1) goes out on the accept edge; the rest here.
  assign w_pre_tms = (r_op == OP_RESET) || ((r_op == OP_IR_SCAN) && (r_cnt == LEN_W'(1)));

  // A bit is consumed by the TAP on every edge the mirror spends in a Shift state.
  assign w_capture = ((r_state == SEQ_SHIFT) || (r_state == SEQ_POST)) &&
                     ((w_tap_state == SHIFT_IR) || (w_tap_state == SHIFT_DR));

  // Raised on the edge the TAP re-enters Run-Test/Idle (or the idle count ends).
  assign w_rsp_set = ((r_state == SEQ_POST) && (r_cnt == LEN_W'(2))) ||
                     ((r_state == SEQ_IDLE_RUN) && (r_cnt >= r_len));

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      r_state     <= SEQ_INIT;
      r_op        <= OP_RESET;
      r_len       <= '0;
      r_cnt       <= '0;
      r_cap       <= '0;
      r_sr        <= '0;
      r_rsp       <= '0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tdi <= 1'b0;
      if (w_capture) begin
        r_rsp[r_cap] <= tdo;
        r_cap        <= r_cap + IDX_W'(1);
      end
      case (r_state)
        // tms is 1 out of reset; present one 0 so the TAP steps TLR -> RTI.
        SEQ_INIT: begin
          if (r_tms) begin
            r_tms <= 1'b0;
          end else begin
            r_state     <= SEQ_READY;
            r_cmd_ready <= 1'b1;
          end
        end
        SEQ_READY: begin
          r_tms <= 1'b0;
          if (cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_op        <= cmd_op_t'(cmd_op);
            r_sr        <= cmd_data;
            r_rsp       <= '0;
            r_cap       <= '0;
            r_cnt       <= LEN_W'(1);
            case (cmd_op_t'(cmd_op))
              OP_IDLE: begin
                r_len   <= cmd_len;
                r_state <= SEQ_IDLE_RUN;
              end
              OP_RESET: begin
                r_tms   <= 1'b1;
                r_state <= SEQ_PRE;
              end
              default: begin
                if (w_n == '0) begin
                  // Empty scan: no TAP activity, answer on the next edge.
                  r_len   <= LEN_W'(1);
                  r_state <= SEQ_IDLE_RUN;
                end else begin
                  r_len   <= w_n;
                  r_tms   <= 1'b1;
                  r_state <= SEQ_PRE;
                end
              end
            endcase
          end
        end
        SEQ_PRE: begin
          r_tms <= w_pre_tms;
          r_cnt <= r_cnt + LEN_W'(1);
          if (w_pre_last) begin
            if (r_op == OP_RESET) begin
              r_state <= SEQ_POST;   // skip the Exit1->Update step, just return to RTI
              r_cnt   <= LEN_W'(1);
            end else begin
              r_state <= SEQ_SHIFT;
              r_cnt   <= '0;
            end
          end
        end
        SEQ_SHIFT: begin
          r_tms <= (r_cnt == r_len - LEN_W'(1));
          r_tdi <= r_sr[0];
          r_sr  <= r_sr >> 1;
          r_cnt <= r_cnt + LEN_W'(1);
          if (r_cnt == r_len - LEN_W'(1)) begin
            r_state <= SEQ_POST;
            r_cnt   <= '0;
          end
        end
        SEQ_POST: begin
          r_tms <= (r_cnt == '0);
          r_cnt <= r_cnt + LEN_W'(1);
          if (w_rsp_set) begin
            r_rsp_valid <= 1'b1;
            r_state     <= SEQ_RESP;
          end
        end
        SEQ_IDLE_RUN: begin
          r_tms <= 1'b0;
          r_cnt <= r_cnt + LEN_W'(1);
          if (w_rsp_set) begin
            r_rsp_valid <= 1'b1;
            r_state     <= SEQ_RESP;
          end
        end
        SEQ_RESP: begin
          r_tms <= 1'b0;
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= SEQ_READY;
          end
        end
        default: r_state <= SEQ_INIT;
      endcase
    end
  end

`ifdef JTAG_SEQ_TDO_PARITY_EN
  logic r_parity;
  // Unused high bits of r_rsp are zero, so a full-width XOR covers exactly N bits.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n)        r_parity <= 1'b0;
    else if (w_rsp_set) r_parity <= ^r_rsp;
  end
  assign rsp_parity = r_parity;
`endif

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp;
  assign tms       = r_tms;
  assign tdi       = r_tdi;
  assign busy      = r_busy;
  assign tap_state = w_tap_state;

endmodule
